systolic_drain_controller: RTL

Result-drain controller for the N×N systolic MAC array. After a matrix multiply finishes, it takes the array out of accumulate mode and shifts the per-PE results down each column's c chain. It captures the bottom-row column bus once per shift and buffers all N rows. It then delivers the rows one at a time to the downstream consumer over a valid/ready handshake. It is the reader side of the c_in/c_out shift chain that the processing elements write into.

---
 rtl/systolic_drain_controller.sv | 90 +++++++++
 1 files changed

// File: rtl/systolic_drain_controller.sv
// systolic_drain_controller: shifts results out of the systolic array's c chain into a row buffer, then streams the rows over valid/ready (macro DRAIN_REORDER_EN: send rows ascending 0..N-1, otherwise in capture order N-1..0)
module systolic_drain_controller #(
  parameter int N = 4,
  parameter int RW = ($clog2(N) < 1) ? 1 : $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            drain_req,
  input  logic [N*8-1:0]  c_col,
  output logic            mode,
  output logic            busy,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [N*8-1:0]  res_data,
  output logic [RW-1:0]   res_row,
  output logic            done
);
  typedef enum logic [1:0] {IDLE, DRAIN, SEND, DONE} state_t;
  localparam logic [RW-1:0] TOP = RW'(N - 1);
  state_t state;
  logic [RW-1:0] k;
  logic [N*8-1:0] rows_q [N];
  logic [RW-1:0] slot;
  logic [RW-1:0] next_row;
  logic [RW-1:0] first_row;
  logic [RW-1:0] last_row;
  logic [N*8-1:0] first_data;
  assign slot = TOP - k;
`ifdef DRAIN_REORDER_EN
  // Row 0 is captured on the final shift edge, so it is forwarded straight from the bus.
  assign first_row = '0;
  assign last_row = TOP;
  assign next_row = res_row + RW'(1);
  assign first_data = c_col;
`else
  assign first_row = TOP;
  assign last_row = '0;
  assign next_row = res_row - RW'(1);
  assign first_data = rows_q[N-1];
`endif
  // Drain/send sequencer with registered outputs and buffer writes.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      k <= '0;
      mode <= 1'b0;
      busy <= 1'b0;
      res_valid <= 1'b0;
      done <= 1'b0;
      res_data <= '0;
      res_row <= '0;
      for (int i = 0; i < N; i++) rows_q[i] <= '0;
    end else begin
      case (state)
        IDLE: if (drain_req) begin
          state <= DRAIN;
          k <= '0;
          mode <= 1'b1;
          busy <= 1'b1;
        end
        DRAIN: begin
          rows_q[slot] <= c_col;
          k <= k + RW'(1);
          if (k == TOP) begin
            state <= SEND;
            mode <= 1'b0;
            res_valid <= 1'b1;
            res_row <= first_row;
            res_data <= first_data;
          end
        end
        SEND: if (res_ready) begin
          if (res_row == last_row) begin
            state <= DONE;
            res_valid <= 1'b0;
            done <= 1'b1;
          end else begin
            res_row <= next_row;
            res_data <= rows_q[next_row];
          end
        end
        DONE: begin
          state <= IDLE;
          done <= 1'b0;
          busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
endmodule
